// File: rtl/moving_average_filter_mc_if.sv
// Sample/result bus between the ADC sequencer, the moving average filter and the
// overcurrent comparator. The master side is the upstream/downstream
// environment; the slave side is the filter.
interface moving_average_filter_mc_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_channel;
  logic [DATA_W-1:0] adc_data_in;
  logic              out_valid;
  logic [CH_W-1:0]   out_channel;
  logic [DATA_W-1:0] filtered_data_out;
  logic              out_primed;

  modport master (
    output in_valid,
    output in_channel,
    output adc_data_in,
    input  in_ready,
    input  out_valid,
    input  out_channel,
    input  filtered_data_out,
    input  out_primed
  );

  modport slave (
    input  in_valid,
    input  in_channel,
    input  adc_data_in,
    output in_ready,
    output out_valid,
    output out_channel,
    output filtered_data_out,
    output out_primed
  );
endinterface

// File: rtl/moving_average_filter_mc.sv
// Multi-channel moving average filter. One shared running-sum datapath serves
// all channels; each channel owns a power-of-two circular window. After reset or
// clear the whole window memory is swept to zero one word per cycle.
module moving_average_filter_mc #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LOG2_DEPTH = 3,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned CH_W       = 2
) (
  input logic                     clk,
  input logic                     reset,
  input logic                     clear,
  moving_average_filter_mc_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;

  typedef enum logic {StClear, StRun} state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       clr_ch_q, clr_ch_d;
  logic [LOG2_DEPTH-1:0] clr_wp_q, clr_wp_d;

  logic [DATA_W-1:0]     buf_q  [CHANNELS][DEPTH];
  logic [SUM_W-1:0]      sum_q  [CHANNELS];
  logic [LOG2_DEPTH-1:0] wp_q   [CHANNELS];
  logic [FILL_W-1:0]     fill_q [CHANNELS];

  logic                  out_valid_q;
  logic [CH_W-1:0]       out_channel_q;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_primed_q;

  logic                  flush;
  logic                  ch_ok;
  logic                  accept;
  logic [CH_W-1:0]       acc_ch;
  logic [LOG2_DEPTH-1:0] acc_wp;
  logic [DATA_W-1:0]     oldest;
  logic [SUM_W-1:0]      sum_new;
  logic [FILL_W-1:0]     fill_new;

  assign flush = reset | clear;

  // Next-state logic: sweep the clear address across every channel's window.
  always_comb begin
    state_d  = state_q;
    clr_ch_d = clr_ch_q;
    clr_wp_d = clr_wp_q;
    if (flush) begin
      state_d  = StClear;
      clr_ch_d = '0;
      clr_wp_d = '0;
    end else if (state_q == StClear) begin
      clr_wp_d = clr_wp_q + LOG2_DEPTH'(1);
      if (clr_wp_q == LOG2_DEPTH'(DEPTH - 1)) begin
        if (32'(clr_ch_q) == CHANNELS - 1) begin
          state_d  = StRun;
          clr_ch_d = '0;
        end else begin
          clr_ch_d = clr_ch_q + CH_W'(1);
        end
      end
    end
  end

  // FSM state and clear-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StClear;
      clr_ch_q <= '0;
      clr_wp_q <= '0;
    end else begin
      state_q  <= state_d;
      clr_ch_q <= clr_ch_d;
      clr_wp_q <= clr_wp_d;
    end
  end

  // Shared datapath: read the oldest word and form the updated sum and fill.
  always_comb begin
    ch_ok    = 32'(bus.in_channel) < CHANNELS;
    accept   = bus.in_valid && bus.in_ready && ch_ok;
    // Out-of-range channels never index the arrays.
    acc_ch   = ch_ok ? bus.in_channel : '0;
    acc_wp   = wp_q[acc_ch];
    oldest   = buf_q[acc_ch][acc_wp];
    sum_new  = sum_q[acc_ch] + SUM_W'(bus.adc_data_in) - SUM_W'(oldest);
    fill_new = (fill_q[acc_ch] == FILL_W'(DEPTH)) ? fill_q[acc_ch]
                                                  : fill_q[acc_ch] + FILL_W'(1);
  end

  assign bus.in_ready = (state_q == StRun) && !flush;

  // Window memory: zero sweep during clear, sample write on accept. No reset so
  // it can map onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      buf_q[clr_ch_q][clr_wp_q] <= '0;
    end else if (accept) begin
      buf_q[acc_ch][acc_wp] <= bus.adc_data_in;
    end
  end

  // Per-channel running sum, write pointer and fill counter.
  always_ff @(posedge clk) begin
    if (flush || state_q == StClear) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        sum_q[i]  <= '0;
        wp_q[i]   <= '0;
        fill_q[i] <= '0;
      end
    end else if (accept) begin
      sum_q[acc_ch]  <= sum_new;
      wp_q[acc_ch]   <= acc_wp + LOG2_DEPTH'(1);
      fill_q[acc_ch] <= fill_new;
    end
  end

  // Result registers; clear leaves them alone, only reset zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_data_q    <= '0;
      out_primed_q  <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_channel_q <= acc_ch;
        out_data_q    <= sum_new[SUM_W-1:LOG2_DEPTH];
        out_primed_q  <= (fill_new == FILL_W'(DEPTH));
      end
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.out_channel       = out_channel_q;
  assign bus.filtered_data_out = out_data_q;
  assign bus.out_primed        = out_primed_q;

endmodule

// File: doc/moving_average_filter_mc.md
Name: moving_average_filter_mc

Overview:
Multi-channel, parametrised moving average filter for the overcurrent relay front end. It time-multiplexes up to CHANNELS ADC streams (default three phase currents) through a single running-sum datapath. Each channel keeps its own power-of-two sample window in a circular buffer. Upstream is the ADC sequencer (valid/ready); downstream is the overcurrent comparator, which uses out_primed to ignore averages taken before the window has filled.

Parameters:
DATA_W, 16, unsigned sample width (in and out)
LOG2_DEPTH, 3, log2 of window length; DEPTH = 2**LOG2_DEPTH = 8
CHANNELS, 3, number of independent channels (1..2**CH_W)
CH_W, 2, channel index width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; starts the CLEAR sequence
clear  in  1  synchronous flush request; same effect as reset on the filter state, output registers untouched
in_valid  in  1  sample present
in_ready  out  1  filter can accept a sample this cycle
in_channel  in  CH_W  channel of the presented sample
adc_data_in  in  DATA_W  unsigned sample
out_valid  out  1  one-cycle pulse, result valid
out_channel  out  CH_W  channel of the result
filtered_data_out  out  DATA_W  window average
out_primed  out  1  the result's channel has received at least DEPTH samples since the last clear

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- FSM states are CLEAR and RUN.
  - reset or clear (sampled high at an edge) -> CLEAR, clear address = 0.
  - CLEAR: writes 0 to one buffer word per cycle, addresses 0..CHANNELS*DEPTH-1. On the last word -> RUN.
  - CLEAR also zeroes every channel's running sum, write pointer and fill counter. Default CLEAR lasts 24 cycles.
  - reset/clear asserted while in CLEAR restarts the sweep from address 0.
- in_ready = 1 only in RUN and not while reset/clear is high.
  - Accept = in_valid && in_ready && in_channel < CHANNELS.
  - in_channel >= CHANNELS: the sample is dropped, no output is produced, no state changes.
- Reset values: in_ready 0, out_valid 0, out_channel 0, filtered_data_out 0, out_primed 0.
- Datapath on accept at edge N, for channel c:
  - oldest = buf[c][wp[c]].
  - sum[c] <= sum[c] + adc_data_in - oldest. The sum is DATA_W+LOG2_DEPTH bits wide and cannot overflow.
  - buf[c][wp[c]] <= adc_data_in; wp[c] <= wp[c]+1 mod DEPTH (natural wrap).
  - fill[c] saturates at DEPTH.
- Outputs after edge N+1 (latency 1 cycle):
  - out_valid = 1; out_channel = c.
  - filtered_data_out = new sum >> LOG2_DEPTH (truncating, no rounding).
  - out_primed = (fill after this sample == DEPTH).
  - Before the window fills, the average includes zeros (ramps up from 0).
- Throughput is one sample per cycle, with back-to-back accepts on the same or different channels.
  - Same channel on consecutive cycles must use the updated sum and pointer (forward or read-after-write safe). No stall is allowed.
- out_valid is 0 in every cycle without an accept on the previous edge; the data/channel outputs hold their last value.
- clear or reset mid-stream: an accept in the same cycle is not taken (in_ready already 0). A result pulse already registered still presents normally.
- Buffer may be registers or inferred RAM. The read of oldest must be combinational or pre-fetched so that latency stays at 1.

Test Plan:
- Reset 2 cycles -> in_ready stays 0 for 24 cycles after reset release, then 1; all outputs 0 during CLEAR.
- Ch0 constant 1000 for 8 samples -> outputs 125,250,375,500,625,750,875,1000; out_primed 0 for the first 7 results, 1 on the 8th.
- After priming, ch0 steps to 200 for 8 samples -> outputs 900,800,...,200; out_primed stays 1.
- Interleave ch0=1000, ch1=400, ch2=65535 round-robin back-to-back for 24 samples -> final results 1000, 400, 65535 per channel with out_channel matching; no cross-channel contamination and no overflow.
- Ch0 fed 8, 8, 9, 10, 11, 12, 13, 14 back-to-back -> last result 10 (85>>3); same-channel consecutive accepts must not use a stale sum.
- Clear asserted mid-stream after ch0 is primed at 1000 -> 24-cycle in_ready gap; next ch0 sample of 1000 gives 125, out_primed 0. A sample with in_channel=3 gives no out_valid and no state change.
